// File: rtl/clock_divider_ctrl.sv
// ============================================================================
// Module   : clock_divider_ctrl
// Even-ratio divided-clock generator with glitch-free run-time divisor update
// and clean start/stop sequencing. Optional macro CLOCK_DIVIDER_CTRL_STATS_EN
// adds saturating rising-edge and rejected-config counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module clock_divider_ctrl #(
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             cfg_valid_i,
    input  logic [CNT_W-1:0] cfg_div_i,
    output logic             cfg_ready_o,
    output logic             cfg_err_o,
    output logic             clk_div_o,
    output logic             tick_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] div_active_o
`ifdef CLOCK_DIVIDER_CTRL_STATS_EN
    ,
    output logic [31:0]      period_cnt_o,
    output logic [7:0]       err_cnt_o
`endif
);

    if ((DEFAULT_DIV < 2) || ((DEFAULT_DIV % 2) != 0)) begin : g_bad_default_div
        $error("clock_divider_ctrl: DEFAULT_DIV must be even and >= 2");
    end

    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_TWO     = CNT_W'(2);
    localparam logic [CNT_W-1:0] C_DEF_DIV = CNT_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2,
        S_STOP = 2'd3
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] pend_div_q;
    logic             pend_vld_q;
    logic             clk_div_q;
    logic             tick_q;
    logic             err_q;

    logic [CNT_W-1:0] w_half_m1;
    logic             w_wrap;
    logic             w_xfer;
    logic             w_bad;
    logic             w_good;
    logic             w_counting;
    logic             w_rise;

    assign w_half_m1  = (div_q >> 1) - C_ONE;
    assign w_wrap     = (cnt_q == w_half_m1);
    assign w_xfer     = cfg_valid_i && !pend_vld_q;
    assign w_bad      = cfg_div_i[0] || (cfg_div_i < C_TWO);
    assign w_good     = w_xfer && !w_bad;
    assign w_counting = (state_q == S_RUN) || (state_q == S_PEND);
    assign w_rise     = w_counting && w_wrap && !clk_div_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= C_DEF_DIV;
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            clk_div_q  <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tick_q <= w_rise;
            err_q  <= w_xfer && w_bad;

            if (w_counting) begin
                if (w_wrap) begin
                    cnt_q     <= '0;
                    clk_div_q <= ~clk_div_q;
                end else begin
                    cnt_q <= cnt_q + C_ONE;
                end
            end

            case (state_q)
                S_IDLE: begin
                    cnt_q     <= '0;
                    clk_div_q <= 1'b0;
                    if (w_good) begin
                        div_q <= cfg_div_i;
                    end
                    if (enable_i) begin
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_good) begin
                        pend_div_q <= cfg_div_i;
                        pend_vld_q <= 1'b1;
                        state_q    <= S_PEND;
                    end
                    if (!enable_i) begin
                        state_q <= S_STOP;
                    end
                end
                S_PEND: begin
                    // New divisor takes over at the high->low edge so it starts
                    // with a full low phase.
                    if (w_wrap && clk_div_q) begin
                        div_q      <= pend_div_q;
                        pend_vld_q <= 1'b0;
                        state_q    <= enable_i ? S_RUN : S_STOP;
                    end else if (!enable_i) begin
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (!clk_div_q || w_wrap) begin
                        cnt_q     <= '0;
                        clk_div_q <= 1'b0;
                        state_q   <= S_IDLE;
                        if (pend_vld_q) begin
                            div_q      <= pend_div_q;
                            pend_vld_q <= 1'b0;
                        end else if (w_good) begin
                            div_q <= cfg_div_i;
                        end
                    end else begin
                        cnt_q <= cnt_q + C_ONE;
                        if (w_good) begin
                            pend_div_q <= cfg_div_i;
                            pend_vld_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef CLOCK_DIVIDER_CTRL_STATS_EN
    logic [31:0] period_cnt_q;
    logic [7:0]  err_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_cnt_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            if (w_rise && (period_cnt_q != 32'hFFFF_FFFF)) begin
                period_cnt_q <= period_cnt_q + 32'd1;
            end
            if (w_xfer && w_bad && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign period_cnt_o = period_cnt_q;
    assign err_cnt_o    = err_cnt_q;
`endif

    assign cfg_ready_o  = !pend_vld_q;
    assign cfg_err_o    = err_q;
    assign clk_div_o    = clk_div_q;
    assign tick_o       = tick_q;
    assign busy_o       = (state_q != S_IDLE);
    assign div_active_o = div_q;

endmodule

`default_nettype wire

// File: tb/tb_clock_divider_ctrl.sv
// ============================================================================
// Module   : tb_clock_divider_ctrl
// Directed plus randomized bench for clock_divider_ctrl with a phase-position
// reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_clock_divider_ctrl;

    localparam int CNT_W       = 16;
    localparam int DEFAULT_DIV = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic             vld;
    logic [CNT_W-1:0] cdiv;
    wire              cfg_ready_o;
    wire              cfg_err_o;
    wire              clk_div_o;
    wire              tick_o;
    wire              busy_o;
    wire [CNT_W-1:0]  div_active_o;
`ifdef CLOCK_DIVIDER_CTRL_STATS_EN
    wire [31:0]       period_cnt_o;
    wire [7:0]        err_cnt_o;
`endif

    clock_divider_ctrl #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (en),
        .cfg_valid_i  (vld),
        .cfg_div_i    (cdiv),
        .cfg_ready_o  (cfg_ready_o),
        .cfg_err_o    (cfg_err_o),
        .clk_div_o    (clk_div_o),
        .tick_o       (tick_o),
        .busy_o       (busy_o),
        .div_active_o (div_active_o)
`ifdef CLOCK_DIVIDER_CTRL_STATS_EN
        ,
        .period_cnt_o (period_cnt_o),
        .err_cnt_o    (err_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: mode 0=idle 1=running 2=stopping; m_pos is the clk_i cycle index
    // inside the current output period (output high when m_pos >= div/2).
    int      m_mode;
    int      m_pos;
    int      m_div;
    int      m_pend;
    bit      m_tick;
    bit      m_err;
    longint  m_pcnt;
    int      m_ecnt;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        assert (act === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic model_step();
        int  half;
        int  np;
        bit  xfer;
        bit  bad_v;
        bit  good;
        if (rst) begin
            m_mode = 0; m_pos = 0; m_div = DEFAULT_DIV; m_pend = -1;
            m_tick = 0; m_err = 0; m_pcnt = 0; m_ecnt = 0;
            return;
        end
        half   = m_div / 2;
        xfer   = vld && (m_pend < 0);
        bad_v  = ((int'(cdiv) % 2) == 1) || (int'(cdiv) < 2);
        good   = xfer && !bad_v;
        m_err  = xfer && bad_v;
        m_tick = 0;
        if (m_err && m_ecnt < 255) m_ecnt++;
        case (m_mode)
            0: begin
                if (good) m_div = int'(cdiv);
                if (en) m_mode = 1;
            end
            1: begin
                np = m_pos + 1;
                if (np == half) m_tick = 1;
                if (np == m_div) begin
                    np = 0;
                    if (m_pend >= 0) begin m_div = m_pend; m_pend = -1; end
                end
                m_pos = np;
                if (good) m_pend = int'(cdiv);
                if (!en) m_mode = 2;
            end
            default: begin
                if (m_pos >= half && m_pos + 1 < m_div) begin
                    m_pos++;
                    if (good) m_pend = int'(cdiv);
                end else begin
                    m_pos = 0;
                    if (m_pend >= 0) begin m_div = m_pend; m_pend = -1; end
                    else if (good) m_div = int'(cdiv);
                    m_mode = 0;
                end
            end
        endcase
        if (m_tick && m_pcnt < 64'h0000_0000_FFFF_FFFF) m_pcnt++;
    endtask

    task automatic check_all();
        bit exp_clk;
        exp_clk = (m_mode != 0) && (m_pos >= m_div / 2);
        chk("clk_div",    clk_div_o,    exp_clk);
        chk("tick",       tick_o,       m_tick);
        chk("cfg_err",    cfg_err_o,    m_err);
        chk("cfg_ready",  cfg_ready_o,  m_pend < 0);
        chk("busy",       busy_o,       m_mode != 0);
        chk("div_active", div_active_o, m_div);
`ifdef CLOCK_DIVIDER_CTRL_STATS_EN
        chk("period_cnt", period_cnt_o, m_pcnt);
        chk("err_cnt",    err_cnt_o,    m_ecnt);
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic offer(input int d);
        vld  = 1'b1;
        cdiv = CNT_W'(d);
        cycle();
        vld  = 1'b0;
    endtask

    task automatic wait_clk_high(input string tag);
        int n = 0;
        while (clk_div_o !== 1'b1 && n < 64) begin cycle(); n++; end
        chk({tag, "_timeout"}, n < 64, 1'b1);
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        while (tick_o !== 1'b1 && n < 64) begin cycle(); n++; end
        chk({tag, "_timeout"}, n < 64, 1'b1);
    endtask

    int div_pool [12] = '{0, 1, 2, 3, 4, 5, 6, 8, 10, 12, 2, 4};

    initial begin
        rst = 1'b1; en = 1'b0; vld = 1'b0; cdiv = '0;
        run(3);
        chk("rst_clk_div", clk_div_o, 1'b0);
        chk("rst_div",     div_active_o, 16'd4);
        chk("rst_ready",   cfg_ready_o, 1'b1);
        chk("rst_busy",    busy_o, 1'b0);

        // Start-up from reset at the default divisor
        rst = 1'b0;
        run(5);
        en = 1'b1;
        run(2);
        chk("start_busy", busy_o, 1'b1);
        run(12);

        // Divisor 10 offered mid high-phase
        wait_clk_high("s2_wait");
        offer(10);
        chk("s2_ready_low", cfg_ready_o, 1'b0);
        run(30);
        chk("s2_div10",   div_active_o, 16'd10);
        chk("s2_ready_hi", cfg_ready_o, 1'b1);

        // Rejected divisors
        offer(7);
        chk("s3_err7", cfg_err_o, 1'b1);
        run(2);
        offer(0);
        chk("s3_err0", cfg_err_o, 1'b1);
        run(12);
        chk("s3_div_kept", div_active_o, 16'd10);

        // Stop at the start of a high phase with divisor 8
        offer(8);
        run(30);
        wait_tick("s4_tick");
        en = 1'b0;
        run(12);
        chk("s4_busy",    busy_o, 1'b0);
        chk("s4_clk_low", clk_div_o, 1'b0);

        // Config transfer coincident with enable fall
        offer(4);
        en = 1'b1;
        run(10);
        en = 1'b0;
        offer(6);
        run(8);
        chk("s5_div6", div_active_o, 16'd6);
        en = 1'b1;
        run(14);

        // Reset while the divided clock is high
        offer(10);
        run(25);
        wait_clk_high("s6_wait");
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("s6_clk_low", clk_div_o, 1'b0);
        chk("s6_div_def", div_active_o, 16'd4);
        chk("s6_ready",   cfg_ready_o, 1'b1);
        run(10);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst  = ($urandom % 300) == 0;
            if (($urandom % 25) == 0) en = ~en;
            vld  = ($urandom % 5) == 0;
            cdiv = CNT_W'(div_pool[$urandom % 12]);
            cycle();
        end
        rst = 1'b0; vld = 1'b0; en = 1'b0;
        run(30);
        chk("final_idle", busy_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clock_divider_ctrl.md
Name: clock_divider_ctrl

Overview:
Run-time controller and generator for an even-ratio divided clock. Accepts divisor updates over a valid/ready config interface and applies them only at a glitch-free boundary. Sequences clean start/stop of the divided output from enable_i. Sits between a config master (CSR/bring-up FSM) and logic clocked or strobed by the divided clock.

Parameters:
CNT_W, 16, width of divisor and internal half-period counter
DEFAULT_DIV, 4, divisor loaded at reset; must be even and >= 2 (elaboration-time check, $error on violation)

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous reset, active-high
enable_i  input  1  level; 1 = run divided clock, 0 = stop cleanly
cfg_valid_i  input  1  divisor update request
cfg_div_i  input  CNT_W  requested divisor
cfg_ready_o  output  1  controller can accept a config word this cycle
cfg_err_o  output  1  one-cycle pulse: offered divisor rejected
clk_div_o  output  1  divided clock, registered
tick_o  output  1  one-cycle pulse in the clk_i cycle where clk_div_o rises
busy_o  output  1  state != IDLE
div_active_o  output  CNT_W  divisor currently in effect

Behaviour:
- Reset, synchronous on rst_i: state=IDLE, clk_div_o=0, tick_o=0, cfg_err_o=0, cfg_ready_o=1, busy_o=0, cnt=0, div_active_o=DEFAULT_DIV, no pending divisor.
- half = div_active_o>>1. cnt counts 0..half-1; at cnt==half-1, clk_div_o toggles next cycle and cnt returns to 0.
- Output period = div_active_o clk_i cycles, 50% duty.
- States:
  - IDLE: clk_div_o=0, cnt held at 0. enable_i=1 -> RUN.
  - RUN: counting. A valid divisor is accepted -> PEND. enable_i=0 -> STOP.
  - PEND: counting on the old divisor with a divisor pending. At the high->low toggle, div_active_o <= pending and cnt=0, so the new divisor starts with a full low phase -> RUN. enable_i=0 -> STOP; the pending divisor is kept.
  - STOP: counting continues. If clk_div_o=1, it finishes the high phase and goes low. If clk_div_o=0, the transition happens on the same cycle. Then cnt=0 and any pending divisor is applied -> IDLE.
  - enable_i reasserting during STOP does not abort STOP; the controller reaches IDLE, then re-enters RUN next cycle.
- Rising edge from IDLE: first rising edge of clk_div_o occurs half clk_i cycles after entering RUN, i.e. a full low phase always precedes it.
- Config handshake:
  - Transfer occurs when cfg_valid_i && cfg_ready_o.
  - cfg_ready_o=0 while a divisor is pending (state PEND, or STOP with a pending value); otherwise 1.
  - Accepted value that is odd or < 2: no state change, cfg_err_o=1 for one cycle, div_active_o unchanged.
  - In IDLE, a valid divisor is applied directly on the next cycle (no PEND).
  - A divisor equal to div_active_o is accepted and applied with no observable change to clk_div_o.
- Simultaneous events:
  - Config transfer and enable_i fall in the same cycle: the divisor is accepted; STOP is taken, and STOP applies the divisor before IDLE.
  - rst_i has priority over everything.
  - Reset mid-phase forces clk_div_o=0 next cycle. The resulting runt pulse is permitted only under reset.
- tick_o is asserted in the same cycle clk_div_o transitions 0->1 (registered together).

Optional Feature:
CLOCK_DIVIDER_CTRL_STATS_EN
- Defined:
  - Adds output period_cnt_o [31:0], the count of rising edges of clk_div_o since reset. Saturates at 0xFFFF_FFFF.
  - Adds output err_cnt_o [7:0], the count of rejected config words. Saturates at 0xFF.
  - Both are cleared by rst_i.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Reset release with DEFAULT_DIV=4, enable_i=1 at cycle 5 -> clk_div_o low 2 cycles, high 2; first tick_o 2 cycles after RUN entry; busy_o=1.
- While running at div=4, offer cfg_div_i=10 mid high-phase -> cfg_ready_o drops; old period completes; after the high->low toggle, 5 low / 5 high cycles; div_active_o=10; cfg_ready_o returns to 1.
- Offer cfg_div_i=7, then cfg_div_i=0 -> cfg_err_o pulses once each; div_active_o and clk_div_o timing unchanged; err_cnt_o=2 when STATS_EN is defined.
- Deassert enable_i at cnt=0 of a high phase with div=8 -> clk_div_o stays high 4 cycles total, then 0; state IDLE; busy_o=0; no further tick_o.
- Config transfer of 6 in the same cycle enable_i falls (div=4) -> STOP; div_active_o=6 on IDLE entry; re-enable gives 3/3 waveform.
- Assert rst_i while clk_div_o=1 at div=10 -> next cycle clk_div_o=0, div_active_o=DEFAULT_DIV, cfg_ready_o=1, period_cnt_o=0.
